// File: rtl/t05_sram_arbiter.sv
// Round-robin arbiter sharing the wishbone manager's CPU-side port among the
// compression-pipeline stages, with a watchdog for strobes the manager never accepts.
module t05_sram_arbiter #(
    parameter int unsigned NREQ    = 5,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 nRST,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      we,
    input  logic [NREQ*32-1:0]   addr,
    input  logic [NREQ*32-1:0]   wdata,
    input  logic [NREQ*4-1:0]    sel,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      done,
    output logic [31:0]          rdata,
    output logic                 err,
    input  logic                 busy_i,
    input  logic [31:0]          mgr_dat_i,
    output logic                 write_o,
    output logic                 read_o,
    output logic [31:0]          addr_o,
    output logic [3:0]           sel_o,
    output logic [31:0]          data_o
);

    localparam int unsigned DW    = 32;
    localparam int unsigned SW    = 4;
    localparam int unsigned WD_W  = 8;
    localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE,
        RESP
    } state_t;

    state_t            state, state_d;
    logic [IDX_W-1:0]  ptr, ptr_d;
    logic [IDX_W-1:0]  g_idx, g_idx_d;
    logic              we_l, we_l_d;
    logic [WD_W-1:0]   wd, wd_d;
    logic [NREQ-1:0]   gnt_d, done_d;
    logic [DW-1:0]     rdata_d, addr_d, data_d;
    logic [SW-1:0]     sel_d;
    logic              err_d, write_d, read_d;

    logic [DW-1:0]     addr_a  [NREQ];
    logic [DW-1:0]     wdata_a [NREQ];
    logic [SW-1:0]     sel_a   [NREQ];

    logic              win_found;
    logic [IDX_W-1:0]  win_idx;
    int unsigned       cand;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign addr_a[gi]  = addr[DW*gi +: DW];
        assign wdata_a[gi] = wdata[DW*gi +: DW];
        assign sel_a[gi]   = sel[SW*gi +: SW];
    end

    // First set request searching upward from ptr, wrapping at NREQ.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            cand = 32'(ptr) + i;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            if (!win_found && req[IDX_W'(cand)]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(cand);
            end
        end
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state   <= IDLE;
            ptr     <= '0;
            g_idx   <= '0;
            we_l    <= 1'b0;
            wd      <= '0;
            gnt     <= '0;
            done    <= '0;
            rdata   <= '0;
            err     <= 1'b0;
            write_o <= 1'b0;
            read_o  <= 1'b0;
            addr_o  <= '0;
            sel_o   <= '0;
            data_o  <= '0;
        end else begin
            state   <= state_d;
            ptr     <= ptr_d;
            g_idx   <= g_idx_d;
            we_l    <= we_l_d;
            wd      <= wd_d;
            gnt     <= gnt_d;
            done    <= done_d;
            rdata   <= rdata_d;
            err     <= err_d;
            write_o <= write_d;
            read_o  <= read_d;
            addr_o  <= addr_d;
            sel_o   <= sel_d;
            data_o  <= data_d;
        end
    end

    // Next-state and next-output values; strobes and done are single-cycle by default.
    always_comb begin
        state_d = state;
        ptr_d   = ptr;
        g_idx_d = g_idx;
        we_l_d  = we_l;
        wd_d    = wd;
        gnt_d   = gnt;
        done_d  = '0;
        rdata_d = rdata;
        err_d   = err;
        write_d = 1'b0;
        read_d  = 1'b0;
        addr_d  = addr_o;
        sel_d   = sel_o;
        data_d  = data_o;

        case (state)
            IDLE: begin
                if (!busy_i && win_found) begin
                    g_idx_d = win_idx;
                    we_l_d  = we[win_idx];
                    addr_d  = addr_a[win_idx];
                    sel_d   = sel_a[win_idx];
                    data_d  = wdata_a[win_idx];
                    gnt_d   = NREQ'(1) << win_idx;
                    write_d = we[win_idx];
                    read_d  = !we[win_idx];
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                wd_d    = '0;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (busy_i) begin
                    state_d = WAIT_DONE;
                end else if (wd == WD_W'(TIMEOUT)) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    done_d  = gnt;
                    state_d = RESP;
                end else begin
                    wd_d = wd + WD_W'(1);
                end
            end
            WAIT_DONE: begin
                if (!busy_i) begin
                    if (!we_l) begin
                        rdata_d = mgr_dat_i;
                    end
                    done_d  = gnt;
                    state_d = RESP;
                end
            end
            RESP: begin
                ptr_d   = (g_idx == IDX_W'(NREQ - 1)) ? '0 : g_idx + IDX_W'(1);
                gnt_d   = '0;
                addr_d  = '0;
                sel_d   = '0;
                data_d  = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_t05_sram_arbiter.sv
// Directed bench for t05_sram_arbiter: the bench plays the manager's busy handshake
// and checks grants, strobes, latencies, read data and the timeout flag.
module tb_t05_sram_arbiter;

    logic          clk = 1'b0;
    logic          nRST;
    logic [4:0]    req, we;
    logic [159:0]  addr, wdata;
    logic [19:0]   sel;
    logic [4:0]    gnt, done;
    logic [31:0]   rdata;
    logic          err;
    logic          busy_i;
    logic [31:0]   mgr_dat_i;
    logic          write_o, read_o;
    logic [31:0]   addr_o;
    logic [3:0]    sel_o;
    logic [31:0]   data_o;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int wcnt = 0, rcnt = 0, dcnt = 0;

    t05_sram_arbiter #(.NREQ(5), .TIMEOUT(255)) dut (
        .clk(clk), .nRST(nRST), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .sel(sel), .gnt(gnt), .done(done), .rdata(rdata), .err(err),
        .busy_i(busy_i), .mgr_dat_i(mgr_dat_i), .write_o(write_o), .read_o(read_o),
        .addr_o(addr_o), .sel_o(sel_o), .data_o(data_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (write_o) wcnt <= wcnt + 1;
        if (read_o)  rcnt <= rcnt + 1;
        if (|done)   dcnt <= dcnt + 1;
    end

    // Plays the manager for one transaction: waits for a strobe, holds busy_i for
    // `hold` cycles (or never raises it when stuck), then waits for done.
    task automatic serve(input int hold, input logic [31:0] rd, input bit stuck,
                         output logic [4:0] g_seen, output logic [31:0] a_seen,
                         output logic [31:0] d_seen, output logic [3:0] s_seen,
                         output bit w_seen, output int t_iss, output int t_dn,
                         output logic [4:0] dn_seen, output logic [31:0] r_seen,
                         output bit ok);
        ok = 1'b0; g_seen = '0; a_seen = '0; d_seen = '0; s_seen = '0;
        w_seen = 1'b0; t_iss = 0; t_dn = 0; dn_seen = '0; r_seen = '0;
        for (int n = 0; n < 400 && !(write_o || read_o); n++) @(negedge clk);
        if (!(write_o || read_o)) return;
        g_seen = gnt; a_seen = addr_o; d_seen = data_o; s_seen = sel_o;
        w_seen = write_o; t_iss = cyc;
        if (!stuck) begin
            @(negedge clk);
            busy_i = 1'b1;
            repeat (hold) @(negedge clk);
            busy_i = 1'b0;
            mgr_dat_i = rd;
        end
        for (int n = 0; n < 400 && done == '0; n++) @(negedge clk);
        if (done == '0) return;
        t_dn = cyc; dn_seen = done; r_seen = rdata; ok = 1'b1;
    endtask

    logic [4:0]  g_s, dn_s;
    logic [31:0] a_s, d_s, r_s;
    logic [3:0]  s_s;
    bit          w_s, ok_s;
    int          t_i, t_d;

    task automatic test_reset();
        nRST = 1'b0; req = '0; we = '0; addr = '0; wdata = '0; sel = '0;
        busy_i = 1'b0; mgr_dat_i = '0;
        repeat (3) @(negedge clk);
        nRST = 1'b1;
        @(negedge clk);
        n_cmp++; if (gnt !== 5'b0) begin n_fail++; $display("FAIL reset_gnt: got %b want 00000", gnt); end
        n_cmp++; if (done !== 5'b0) begin n_fail++; $display("FAIL reset_done: got %b want 00000", done); end
        n_cmp++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", rdata); end
        n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
        n_cmp++; if ({write_o, read_o} !== 2'b00) begin n_fail++; $display("FAIL reset_strobe: got %b want 00", {write_o, read_o}); end
        n_cmp++; if ({addr_o, sel_o, data_o} !== 68'h0) begin n_fail++; $display("FAIL reset_bus: got %h/%h/%h want 0", addr_o, sel_o, data_o); end
    endtask

    task automatic test_single_write();
        int w0, r0, d0;
        we = 5'b00100; addr[64 +: 32] = 32'h3300_0010; wdata[64 +: 32] = 32'hA5A5_0001;
        sel[8 +: 4] = 4'hF; req = 5'b00100;
        w0 = wcnt; r0 = rcnt; d0 = dcnt;
        serve(3, 32'hDEAD_BEEF, 1'b0, g_s, a_s, d_s, s_s, w_s, t_i, t_d, dn_s, r_s, ok_s);
        req = '0;
        @(negedge clk);
        n_cmp++; if (addr_o !== 32'h0) begin n_fail++; $display("FAIL wr_addr_idle: got %h want 0", addr_o); end
        repeat (2) @(negedge clk);
        n_cmp++; if (ok_s !== 1'b1) begin n_fail++; $display("FAIL wr_handshake: got %b want 1 (no strobe or done)", ok_s); end
        n_cmp++; if (g_s !== 5'b00100) begin n_fail++; $display("FAIL wr_gnt: got %b want 00100", g_s); end
        n_cmp++; if (w_s !== 1'b1) begin n_fail++; $display("FAIL wr_dir: got %b want 1", w_s); end
        n_cmp++; if ({a_s, d_s, s_s} !== {32'h3300_0010, 32'hA5A5_0001, 4'hF}) begin n_fail++;
            $display("FAIL wr_bus: got %h/%h/%h want 33000010/a5a50001/f", a_s, d_s, s_s); end
        n_cmp++; if (dn_s !== 5'b00100) begin n_fail++; $display("FAIL wr_done: got %b want 00100", dn_s); end
        n_cmp++; if (t_d - t_i !== 5) begin n_fail++; $display("FAIL wr_latency: got %0d want 5", t_d - t_i); end
        n_cmp++; if (r_s !== 32'h0) begin n_fail++; $display("FAIL wr_rdata: got %h want 0", r_s); end
        n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL wr_err: got %b want 0", err); end
        n_cmp++; if ({wcnt - w0, rcnt - r0, dcnt - d0} !== {32'd1, 32'd0, 32'd1}) begin n_fail++;
            $display("FAIL wr_counts: got w%0d r%0d d%0d want w1 r0 d1", wcnt - w0, rcnt - r0, dcnt - d0); end
    endtask

    task automatic test_read();
        int t_req, r0;
        we = '0; addr[0 +: 32] = 32'h3300_0000; req = 5'b00001;
        t_req = cyc; r0 = rcnt;
        serve(1, 32'h0000_0042, 1'b0, g_s, a_s, d_s, s_s, w_s, t_i, t_d, dn_s, r_s, ok_s);
        req = '0;
        repeat (2) @(negedge clk);
        n_cmp++; if (ok_s !== 1'b1) begin n_fail++; $display("FAIL rd_handshake: got %b want 1", ok_s); end
        n_cmp++; if (t_i - t_req !== 1) begin n_fail++; $display("FAIL rd_issue_lat: got %0d want 1", t_i - t_req); end
        n_cmp++; if (t_d - t_req !== 4) begin n_fail++; $display("FAIL rd_min_lat: got %0d want 4", t_d - t_req); end
        n_cmp++; if ({w_s, a_s} !== {1'b0, 32'h3300_0000}) begin n_fail++; $display("FAIL rd_bus: got %b/%h want 0/33000000", w_s, a_s); end
        n_cmp++; if (r_s !== 32'h42) begin n_fail++; $display("FAIL rd_data: got %h want 42", r_s); end
        n_cmp++; if (dn_s !== 5'b00001) begin n_fail++; $display("FAIL rd_done: got %b want 00001", dn_s); end
        n_cmp++; if (rcnt - r0 !== 1) begin n_fail++; $display("FAIL rd_count: got %0d want 1", rcnt - r0); end
        n_cmp++; if (rdata !== 32'h42) begin n_fail++; $display("FAIL rd_hold: got %h want 42", rdata); end
    endtask

    task automatic test_contention();
        int prev_dn;
        logic [4:0] exp_g;
        nRST = 1'b0; busy_i = 1'b0; we = '0; req = 5'b11111;
        for (int i = 0; i < 5; i++) addr[32*i +: 32] = 32'h3300_0100 + 32'(i * 16);
        @(negedge clk);
        nRST = 1'b1;
        prev_dn = 0;
        for (int k = 0; k < 6; k++) begin
            serve(1, 32'h100 + 32'(k), 1'b0, g_s, a_s, d_s, s_s, w_s, t_i, t_d, dn_s, r_s, ok_s);
            if (k == 5) req = '0;
            exp_g = 5'b00001 << (k % 5);
            n_cmp++; if (g_s !== exp_g) begin n_fail++; $display("FAIL rr_gnt[%0d]: got %b want %b", k, g_s, exp_g); end
            n_cmp++; if (a_s !== 32'h3300_0100 + 32'((k % 5) * 16)) begin n_fail++; $display("FAIL rr_addr[%0d]: got %h", k, a_s); end
            n_cmp++; if ({dn_s, r_s} !== {exp_g, 32'h100 + 32'(k)}) begin n_fail++;
                $display("FAIL rr_done[%0d]: got %b/%h want %b/%h", k, dn_s, r_s, exp_g, 32'h100 + 32'(k)); end
            if (k > 0) begin
                n_cmp++; if (t_i - prev_dn !== 2) begin n_fail++; $display("FAIL rr_gap[%0d]: got %0d want 2", k, t_i - prev_dn); end
            end
            prev_dn = t_d;
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_fairness();
        logic [4:0] exp_g;
        req = 5'b01010;
        for (int k = 0; k < 4; k++) begin
            serve(2, 32'h200 + 32'(k), 1'b0, g_s, a_s, d_s, s_s, w_s, t_i, t_d, dn_s, r_s, ok_s);
            if (k == 3) req = '0;
            exp_g = (k % 2 == 0) ? 5'b00010 : 5'b01000;
            n_cmp++; if ({g_s, dn_s} !== {exp_g, exp_g}) begin n_fail++;
                $display("FAIL fair[%0d]: got gnt %b done %b want %b", k, g_s, dn_s, exp_g); end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_timeout();
        we = '0; addr[128 +: 32] = 32'h3300_0040; req = 5'b10000;
        n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL to_err_before: got %b want 0", err); end
        serve(0, 32'h0, 1'b1, g_s, a_s, d_s, s_s, w_s, t_i, t_d, dn_s, r_s, ok_s);
        req = '0;
        n_cmp++; if ({ok_s, g_s, dn_s} !== {1'b1, 5'b10000, 5'b10000}) begin n_fail++;
            $display("FAIL to_done: got ok%b gnt %b done %b want 1/10000/10000", ok_s, g_s, dn_s); end
        n_cmp++; if (t_d - t_i !== 257) begin n_fail++; $display("FAIL to_latency: got %0d want 257", t_d - t_i); end
        n_cmp++; if (r_s !== 32'h0) begin n_fail++; $display("FAIL to_rdata: got %h want 0", r_s); end
        n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL to_err: got %b want 1", err); end
        @(negedge clk);
        we = 5'b00001; wdata[0 +: 32] = 32'h11; req = 5'b00001;
        serve(2, 32'h0, 1'b0, g_s, a_s, d_s, s_s, w_s, t_i, t_d, dn_s, r_s, ok_s);
        req = '0;
        n_cmp++; if ({ok_s, dn_s, d_s} !== {1'b1, 5'b00001, 32'h11}) begin n_fail++;
            $display("FAIL to_next: got ok%b done %b data %h want 1/00001/11", ok_s, dn_s, d_s); end
        n_cmp++; if (t_d - t_i !== 4) begin n_fail++; $display("FAIL to_next_lat: got %0d want 4", t_d - t_i); end
        n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL to_err_sticky: got %b want 1", err); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int d0;
        we = '0; req = 5'b00010;
        for (int n = 0; n < 20 && !read_o; n++) @(negedge clk);
        n_cmp++; if (read_o !== 1'b1) begin n_fail++; $display("FAIL rst_strobe: got %b want 1", read_o); end
        @(negedge clk);
        busy_i = 1'b1;
        repeat (2) @(negedge clk);
        d0 = dcnt;
        nRST = 1'b0;
        #1;
        n_cmp++; if ({gnt, done, write_o, read_o, err} !== 13'h0) begin n_fail++;
            $display("FAIL rst_ctrl: got gnt %b done %b w%b r%b err%b want all 0", gnt, done, write_o, read_o, err); end
        n_cmp++; if ({addr_o, sel_o, data_o, rdata} !== 100'h0) begin n_fail++;
            $display("FAIL rst_bus: got %h/%h/%h/%h want 0", addr_o, sel_o, data_o, rdata); end
        req = '0; busy_i = 1'b0;
        @(negedge clk);
        nRST = 1'b1;
        repeat (5) @(negedge clk);
        n_cmp++; if ({dcnt - d0, 27'(gnt)} !== {32'd0, 27'd0}) begin n_fail++;
            $display("FAIL rst_no_done: got %0d dones gnt %b want 0", dcnt - d0, gnt); end
    endtask

    task automatic test_busy_idle();
        int w0, t_rel;
        busy_i = 1'b1; we = 5'b01000; addr[96 +: 32] = 32'h3300_0030;
        wdata[96 +: 32] = 32'h0BAD_F00D; sel[12 +: 4] = 4'h3; req = 5'b01000;
        w0 = wcnt;
        repeat (6) @(negedge clk);
        n_cmp++; if ({wcnt - w0, 27'(gnt)} !== {32'd0, 27'd0}) begin n_fail++;
            $display("FAIL busy_idle_hold: got %0d strobes gnt %b want 0", wcnt - w0, gnt); end
        busy_i = 1'b0; t_rel = cyc;
        serve(1, 32'h0, 1'b0, g_s, a_s, d_s, s_s, w_s, t_i, t_d, dn_s, r_s, ok_s);
        req = '0;
        n_cmp++; if ({ok_s, t_i - t_rel} !== {1'b1, 32'd1}) begin n_fail++;
            $display("FAIL busy_idle_issue: got ok%b delay %0d want 1/1", ok_s, t_i - t_rel); end
        n_cmp++; if ({w_s, a_s, d_s, s_s} !== {1'b1, 32'h3300_0030, 32'h0BAD_F00D, 4'h3}) begin n_fail++;
            $display("FAIL busy_idle_bus: got %b/%h/%h/%h", w_s, a_s, d_s, s_s); end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_read();
        test_contention();
        test_fairness();
        test_timeout();
        test_reset_mid();
        test_busy_idle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded 200000 time units");
        $fatal(1);
    end

endmodule
